// File: rtl/gen_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : gen_stream_collector
// Brief    : Launches one generator run, captures every yielded beat into a
//            FIFO and replays it downstream, closed by a terminator beat.
//            Optional statistics outputs: define GEN_COLLECT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gen_stream_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_n,
    output logic             req_ready,
    output logic [WIDTH-1:0] gen_n,
    output logic             gen_start,
    output logic             gen_ready,
    input  logic             gen_valid,
    input  logic             gen_done,
    input  logic [WIDTH-1:0] gen_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             overflow,
    output logic             busy
`ifdef GEN_COLLECT_STATS_EN
    ,
    output logic [WIDTH-1:0] stat_count,
    output logic [WIDTH-1:0] stat_sum
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_START   = 2'd1;
    localparam logic [1:0] c_COLLECT = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic             r_mem_last [DEPTH];
    logic [WIDTH-1:0] r_gen_n;
    logic             r_overflow;

    logic [c_PW-1:0]  w_count;
    logic [c_PW-1:0]  w_free;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_beat;
    logic             w_push;
    logic             w_drop;
    logic             w_launch;

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_free   = c_PW'(DEPTH) - w_count;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop    = !w_empty && out_ready;
    // Beats are taken whenever presented: the producer never holds valid.
    assign w_beat   = (r_state == c_COLLECT) && gen_valid;
    // A same-cycle pop frees the slot before the push lands.
    assign w_push   = w_beat && (!w_full || w_pop);
    assign w_drop   = w_beat && w_full && !w_pop;
    assign w_launch = (r_state == c_IDLE) && req_valid;

    // State register
    always_ff @(posedge __clock) begin
        if (!__reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (req_valid) w_next = c_START;
            c_START:   w_next = c_COLLECT;
            c_COLLECT: if (w_beat && gen_done) w_next = c_DRAIN;
            c_DRAIN:   if (w_empty) w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (r_state == c_IDLE);
        busy      = (r_state != c_IDLE);
        gen_start = (r_state == c_START);
        gen_ready = (r_state == c_START) ||
                    ((r_state == c_COLLECT) && (w_free >= c_PW'(2)));
    end

    always_ff @(posedge __clock) begin
        if (!__reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_gen_n    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            if (w_launch) begin
                r_gen_n    <= req_n;
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge __clock) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr[c_AW-1:0]] <= gen_done ? '0 : gen_data;
            r_mem_last[r_wr_ptr[c_AW-1:0]] <= gen_done;
        end
    end

    assign gen_n     = r_gen_n;
    assign overflow  = r_overflow;
    assign out_valid = !w_empty;
    assign out_data  = r_mem_data[r_rd_ptr[c_AW-1:0]];
    assign out_last  = r_mem_last[r_rd_ptr[c_AW-1:0]];

`ifdef GEN_COLLECT_STATS_EN
    logic [WIDTH-1:0] r_stat_count;
    logic [WIDTH-1:0] r_stat_sum;

    always_ff @(posedge __clock) begin
        if (!__reset || w_launch) begin
            r_stat_count <= '0;
            r_stat_sum   <= '0;
        end else if (w_push && !gen_done) begin
            r_stat_count <= r_stat_count + WIDTH'(1);
            r_stat_sum   <= r_stat_sum + gen_data;
        end
    end

    assign stat_count = r_stat_count;
    assign stat_sum   = r_stat_sum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gen_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_stream_collector
// Brief    : Self-checking bench with a stub generator and a queue-based
//            reference of the expected downstream stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gen_stream_collector;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic [WIDTH-1:0] req_n = '0;
    logic             req_ready;
    logic [WIDTH-1:0] gen_n;
    logic             gen_start;
    logic             gen_ready;
    logic             gen_valid = 1'b0;
    logic             gen_done = 1'b0;
    logic [WIDTH-1:0] gen_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             overflow;
    logic             busy;
`ifdef GEN_COLLECT_STATS_EN
    logic [WIDTH-1:0] stat_count;
    logic [WIDTH-1:0] stat_sum;
`endif

    gen_stream_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .__clock   (clk),
        .__reset   (rst_n),
        .req_valid (req_valid),
        .req_n     (req_n),
        .req_ready (req_ready),
        .gen_n     (gen_n),
        .gen_start (gen_start),
        .gen_ready (gen_ready),
        .gen_valid (gen_valid),
        .gen_done  (gen_done),
        .gen_data  (gen_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .busy      (busy)
`ifdef GEN_COLLECT_STATS_EN
        ,
        .stat_count(stat_count),
        .stat_sum  (stat_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stub generator controls: gen_mode 0 obeys ready, 1 ignores ready, 2 manual.
    // or_mode: 0 out_ready low, 1 high, 2 random, 3 manual.
    int          gen_mode  = 0;
    int          or_mode   = 0;
    int          stall_pct = 0;
    logic [31:0] cfg_q[$];
    logic [31:0] run_q[$];
    bit          active    = 0;
    int          emitted   = 0;
    int          start_cnt = 0;
    bit          ready_s = 0, start_s = 0, rst_s = 0;
    logic [32:0] got_q[$];

    always @(negedge clk) begin
        ready_s = gen_ready;
        start_s = gen_start;
        rst_s   = rst_n;
        if (rst_n && out_valid && out_ready) got_q.push_back({out_last, out_data});
        if (gen_start) start_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (or_mode == 0)      out_ready = 1'b0;
        else if (or_mode == 1) out_ready = 1'b1;
        else if (or_mode == 2) out_ready = 1'($urandom_range(0, 1));
        if (gen_mode != 2) begin
            gen_valid = 1'b0;
            gen_done  = 1'b0;
            if (!rst_s) begin
                active = 0;
            end else begin
                if (start_s) begin
                    active  = 1;
                    run_q   = cfg_q;
                    emitted = 0;
                end
                if (active && (gen_mode == 1 ||
                               (ready_s && $urandom_range(0, 99) >= stall_pct))) begin
                    gen_valid = 1'b1;
                    if (run_q.size() > 0) begin
                        gen_data = run_q.pop_front();
                        emitted++;
                    end else begin
                        gen_done = 1'b1;
                        gen_data = $urandom;
                        active   = 0;
                    end
                end
            end
        end
    end

    function automatic int first_diff(input logic [32:0] a[$], input logic [32:0] b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : n;
    endfunction

    function automatic void build_exp(input logic [31:0] vals[$], input bit with_term,
                                      output logic [32:0] e[$]);
        e.delete();
        foreach (vals[i]) e.push_back({1'b0, vals[i]});
        if (with_term) e.push_back({1'b1, 32'd0});
    endfunction

    task automatic launch(input logic [31:0] n);
        got_q.delete();
        start_cnt = 0;
        req_valid = 1'b1;
        req_n     = n;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_n     = $urandom;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, busy, gen_start, gen_ready, out_valid, overflow} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 100000",
                     {req_ready, busy, gen_start, gen_ready, out_valid, overflow});
        end
        n_tests++;
        if (gen_n !== 32'd0) begin
            n_fail++; $display("FAIL reset_gen_n: got %0d required 0", gen_n);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fib();
        logic [32:0] e[$];
        bit ok;
        gen_mode = 0; stall_pct = 0; or_mode = 1;
        cfg_q = '{32'd1, 32'd1, 32'd3, 32'd5, 32'd13, 32'd21, 32'd55};
        launch(32'd10);
        n_tests++;
        if (!(gen_start === 1'b1 && gen_n === 32'd10 && busy === 1'b1)) begin
            n_fail++;
            $display("FAIL fib_start: got start=%b n=%0d busy=%b required 1/10/1",
                     gen_start, gen_n, busy);
        end
        wait_idle(ok);
        build_exp(cfg_q, 1, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1) begin
            n_fail++;
            $display("FAIL fib_stream: got %0d beats (idle=%0d, diff@%0d) required %0d",
                     got_q.size(), ok, first_diff(got_q, e), e.size());
        end
        n_tests++;
        if (overflow !== 1'b0 || start_cnt != 1 || gen_n !== 32'd10) begin
            n_fail++;
            $display("FAIL fib_misc: got ovf=%b starts=%0d gen_n=%0d required 0/1/10",
                     overflow, start_cnt, gen_n);
        end
`ifdef GEN_COLLECT_STATS_EN
        n_tests++;
        if (stat_count !== 32'd7 || stat_sum !== 32'd99) begin
            n_fail++;
            $display("FAIL fib_stats: got %0d/%0d required 7/99", stat_count, stat_sum);
        end
`endif
    endtask

    task automatic test_zero();
        logic [32:0] e[$];
        bit ok;
        gen_mode = 0; stall_pct = 0; or_mode = 1;
        cfg_q.delete();
        launch(32'd0);
        wait_idle(ok);
        build_exp(cfg_q, 1, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1) begin
            n_fail++;
            $display("FAIL zero_run: got %0d beats (head %h) required 1 beat %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0, e[0]);
        end
`ifdef GEN_COLLECT_STATS_EN
        n_tests++;
        if (stat_count !== 32'd0) begin
            n_fail++; $display("FAIL zero_stats: got %0d required 0", stat_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [32:0] e[$];
        logic [31:0] sum;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            gen_mode = 0; or_mode = 2;
            stall_pct = $urandom_range(0, 60);
            cfg_q.delete();
            sum = 0;
            for (int k = $urandom_range(0, 12); k > 0; k--) begin
                cfg_q.push_back($urandom);
                sum += cfg_q[$];
            end
            launch($urandom);
            wait_idle(ok);
            build_exp(cfg_q, 1, e);
            n_tests++;
            if (!ok || first_diff(got_q, e) != -1 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL random_run%0d: got %0d beats ovf=%b diff@%0d required %0d beats ovf=0",
                         it, got_q.size(), overflow, first_diff(got_q, e), e.size());
            end
`ifdef GEN_COLLECT_STATS_EN
            n_tests++;
            if (stat_count !== 32'(cfg_q.size()) || stat_sum !== sum) begin
                n_fail++;
                $display("FAIL random_stats%0d: got %0d/%h required %0d/%h",
                         it, stat_count, stat_sum, cfg_q.size(), sum);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e[$];
        bit ok;
        gen_mode = 0; stall_pct = 0; or_mode = 0;
        cfg_q.delete();
        for (int k = 0; k < 10; k++) cfg_q.push_back(32'h100 + 32'(k));
        launch(32'd10);
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (emitted != DEPTH || gen_ready !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_hold: got beats=%0d rdy=%b ovf=%b ov=%b required %0d/0/0/1",
                     emitted, gen_ready, overflow, out_valid, DEPTH);
        end
        or_mode = 1;
        wait_idle(ok);
        build_exp(cfg_q, 1, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_stream: got %0d beats ovf=%b required %0d ovf=0",
                     got_q.size(), overflow, e.size());
        end
    endtask

    task automatic test_overflow();
        logic [32:0] e[$];
        logic [31:0] kept[$];
        bit ok;
        gen_mode = 1; or_mode = 0;
        cfg_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        launch(32'd6);
        repeat (12) @(posedge clk);
        #1;
        n_tests++;
        if (overflow !== 1'b1 || busy !== 1'b1 || emitted != 6) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%b busy=%b beats=%0d required 1/1/6",
                     overflow, busy, emitted);
        end
        or_mode = 1;
        wait_idle(ok);
        kept = cfg_q[0:3];
        build_exp(kept, 0, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d beats ovf=%b required 4 beats ovf=1",
                     got_q.size(), overflow);
        end
`ifdef GEN_COLLECT_STATS_EN
        n_tests++;
        if (stat_count !== 32'd4) begin
            n_fail++; $display("FAIL overflow_stats: got %0d required 4", stat_count);
        end
`endif
        gen_mode = 0;
        cfg_q = '{32'd7};
        launch(32'd1);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clear: got %b required 0", overflow);
        end
        wait_idle(ok);
        build_exp(cfg_q, 1, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1) begin
            n_fail++;
            $display("FAIL overflow_rerun: got %0d beats required %0d", got_q.size(), e.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        gen_mode = 0; stall_pct = 0; or_mode = 0;
        cfg_q.delete();
        for (int k = 0; k < 10; k++) cfg_q.push_back(32'h200 + 32'(k));
        launch(32'd10);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            if (emitted >= 2) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_tests++;
        if (!ok || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_queued: got ov=%b busy=%b reached=%0d required 1/1/1",
                     out_valid, busy, ok);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({busy, out_valid, gen_start, req_ready, overflow, gen_ready} !== 6'b000100) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b required 000100",
                     {busy, out_valid, gen_start, req_ready, overflow, gen_ready});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [32:0] e[$];
        logic [31:0] vals[$];
        bit ok;
        gen_mode = 2; or_mode = 3;
        out_ready = 1'b0;
        gen_valid = 1'b0; gen_done = 1'b0;
        launch(32'd5);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            gen_valid = 1'b1;
            gen_data  = 32'hC0 + 32'(i);
            vals.push_back(gen_data);
            @(posedge clk); #1;
        end
        gen_data  = 32'hC0 + 32'(DEPTH);
        vals.push_back(gen_data);
        out_ready = 1'b1;
        n_tests++;
        if (gen_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hC0) begin
            n_fail++;
            $display("FAIL full_before: got rdy=%b ov=%b head=%h required 0/1/c0",
                     gen_ready, out_valid, out_data);
        end
        @(posedge clk); #1;
        n_tests++;
        if (overflow !== 1'b0 || gen_ready !== 1'b0 || out_data !== 32'hC1) begin
            n_fail++;
            $display("FAIL full_pushpop: got ovf=%b rdy=%b head=%h required 0/0/c1",
                     overflow, gen_ready, out_data);
        end
        gen_done = 1'b1;
        @(posedge clk); #1;
        gen_valid = 1'b0; gen_done = 1'b0;
        or_mode = 1;
        wait_idle(ok);
        build_exp(vals, 1, e);
        n_tests++;
        if (!ok || first_diff(got_q, e) != -1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_order: got %0d beats ovf=%b diff@%0d required %0d ovf=0",
                     got_q.size(), overflow, first_diff(got_q, e), e.size());
        end
`ifdef GEN_COLLECT_STATS_EN
        n_tests++;
        if (stat_count !== 32'(DEPTH + 1)) begin
            n_fail++; $display("FAIL full_stats: got %0d required %0d", stat_count, DEPTH + 1);
        end
`endif
        gen_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fib();
        test_zero();
        test_random();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
